// File: rtl/buzzer_tone_gen_if.sv
// Signal bundle between the auto-play sequencer and the buzzer tone generator.
//
// Handshake semantics: there is no valid/ready pair. The sequencer drives
// enable/note/octave as levels. The tone generator samples them only at a
// full-period boundary, or on the first cycle while silent. The outputs
// speaker/sounding/period_tick are registered levels/pulses that any
// observer may sample at any time.
interface buzzer_tone_gen_if;
  logic       enable;
  logic [3:0] note;
  logic [1:0] octave;
  logic       speaker;
  logic       sounding;
  logic       period_tick;

  // Sequencer side: drives the tone request, observes the buzzer status.
  modport master (
    output enable,
    output note,
    output octave,
    input  speaker,
    input  sounding,
    input  period_tick
  );

  // Tone generator side.
  modport slave (
    input  enable,
    input  note,
    input  octave,
    output speaker,
    output sounding,
    output period_tick
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Buzzer square-wave generator. A per-note half-period counter toggles the
// speaker pin. Note, octave and enable are only re-sampled at full-period
// boundaries, so the buzzer never sees a truncated pulse. The sounding output
// is the registered FSM state (PLAY) and doubles as the debug view of the FSM.
module buzzer_tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20
) (
  input  logic               clk,
  input  logic               reset,
  buzzer_tone_gen_if.slave   bus
);

  // Mid-octave half-periods, truncating division, fixed at elaboration.
  localparam logic [CNT_W-1:0] HP_C = CNT_W'(CLK_HZ / (2 * 262));
  localparam logic [CNT_W-1:0] HP_D = CNT_W'(CLK_HZ / (2 * 294));
  localparam logic [CNT_W-1:0] HP_E = CNT_W'(CLK_HZ / (2 * 330));
  localparam logic [CNT_W-1:0] HP_F = CNT_W'(CLK_HZ / (2 * 349));
  localparam logic [CNT_W-1:0] HP_G = CNT_W'(CLK_HZ / (2 * 392));
  localparam logic [CNT_W-1:0] HP_A = CNT_W'(CLK_HZ / (2 * 440));
  localparam logic [CNT_W-1:0] HP_B = CNT_W'(CLK_HZ / (2 * 494));

  typedef enum logic {
    SILENT = 1'b0,
    PLAY   = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp;
  logic             speaker_q;
  logic             sounding_q;
  logic             period_tick_q;

  logic             in_valid;
  logic [CNT_W-1:0] hp_sel;
  logic [CNT_W-1:0] hp_mid;
  logic             phase_end;

  // Half-period for the current (note, octave); only meaningful when in_valid.
  always_comb begin
    hp_mid = '0;
    case (bus.note)
      4'd1:    hp_mid = HP_C;
      4'd2:    hp_mid = HP_D;
      4'd3:    hp_mid = HP_E;
      4'd4:    hp_mid = HP_F;
      4'd5:    hp_mid = HP_G;
      4'd6:    hp_mid = HP_A;
      4'd7:    hp_mid = HP_B;
      default: hp_mid = '0;
    endcase
    hp_sel = hp_mid;
    case (bus.octave)
      2'd0:    hp_sel = hp_mid << 1;
      2'd2:    hp_sel = hp_mid >> 1;
      default: hp_sel = hp_mid;
    endcase
  end

  // A tone is requested when enabled, the note is C..B and the octave is audible.
  assign in_valid  = bus.enable && (bus.note >= 4'd1) && (bus.note <= 4'd7)
                     && (bus.octave != 2'd3);
  assign phase_end = (cnt == hp - CNT_W'(1));

  // Tone FSM: SILENT waits for a valid request; PLAY counts out high and low
  // phases and re-samples the inputs only when the low phase completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SILENT;
      cnt           <= '0;
      hp            <= '0;
      speaker_q     <= 1'b0;
      sounding_q    <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      period_tick_q <= 1'b0;
      case (state)
        SILENT: begin
          cnt       <= '0;
          speaker_q <= 1'b0;
          if (in_valid) begin
            hp         <= hp_sel;
            speaker_q  <= 1'b1;
            state      <= PLAY;
            sounding_q <= 1'b1;
          end
        end
        PLAY: begin
          if (phase_end) begin
            cnt <= '0;
            if (speaker_q) begin
              // High phase done: drop into the low phase of the same period.
              speaker_q <= 1'b0;
            end else begin
              // Full period done: the only point where inputs take effect.
              period_tick_q <= 1'b1;
              if (in_valid) begin
                hp        <= hp_sel;
                speaker_q <= 1'b1;
              end else begin
                state      <= SILENT;
                sounding_q <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= SILENT;
          sounding_q <= 1'b0;
          speaker_q  <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

  assign bus.speaker     = speaker_q;
  assign bus.sounding    = sounding_q;
  assign bus.period_tick = period_tick_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen at CLK_HZ = 1 MHz. The driver issues directed
// note/octave/enable changes and pushes the expected phase lengths into a
// queue; a monitor measures the high/low runs of the speaker and pops and
// compares one entry per completed phase.
module tb_buzzer_tone_gen;

  localparam int CLK_HZ = 1_000_000;
  localparam int CNT_W  = 20;
  localparam int W      = 24;

  // Hand-computed half-periods at 1 MHz.
  localparam int HP_A     = 1136;  // 1e6/880
  localparam int HP_A_LOW = 2272;  // octave 0
  localparam int HP_A_HIG = 568;   // octave 2
  localparam int HP_C     = 1908;  // 1e6/524

  // Event kinds: high run, low run ending a period that continues, low run
  // ending a period after which the generator went silent.
  localparam logic [1:0] K_HI = 2'd1;
  localparam logic [1:0] K_LC = 2'd2;
  localparam logic [1:0] K_LS = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  buzzer_tone_gen_if bus ();

  buzzer_tone_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_period(input int hp, input bit stop);
    exp_q.push_back({K_HI, 22'(hp)});
    exp_q.push_back({(stop ? K_LS : K_LC), 22'(hp)});
  endtask

  task automatic emit(input logic [1:0] kind, input int len);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {kind, 22'(len)};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d len %0d, expected none (t=%0t)",
               kind, len, $time);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL phase: got kind %0d len %0d, expected kind %0d len %0d (t=%0t)",
                 got[W-1:W-2], got[W-3:0], e[W-1:W-2], e[W-3:0], $time);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and measures phases.
  logic prev_spk = 1'b0;
  int   hi_len   = 0;
  int   lo_len   = 0;
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      prev_spk = 1'b0;
      hi_len   = 0;
      lo_len   = 0;
    end else begin
      if (bus.speaker) hi_len++;
      if (!bus.speaker && prev_spk) begin
        emit(K_HI, hi_len);
        hi_len = 0;
        lo_len = 1;
      end else if (!bus.speaker && !bus.period_tick) begin
        lo_len++;
      end
      if (bus.period_tick) begin
        emit(bus.sounding ? K_LC : K_LS, lo_len);
        lo_len = 0;
      end
      prev_spk = bus.speaker;
    end
  end

  // Driver helpers; all run at falling edges.
  task automatic set_in(input logic en, input logic [3:0] n, input logic [1:0] o);
    bus.enable = en;
    bus.note   = n;
    bus.octave = o;
  endtask

  task automatic expect_rise(input string name);
    @(negedge clk);
    check({name, "_speaker"}, int'(bus.speaker), 1);
    check({name, "_sounding"}, int'(bus.sounding), 1);
  endtask

  task automatic wait_ticks(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.period_tick && k < 20000);
      if (!bus.period_tick) check({name, "_tick_timeout"}, 0, 1);
    end
  endtask

  task automatic silent_window(input int n, input string name);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.speaker || bus.sounding || bus.period_tick) bad++;
    end
    check(name, bad, 0);
  endtask

  // Watchdog: a hung run still reports before stopping.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(1'b0, 4'd0, 2'd0);
    repeat (3) @(negedge clk);
    check("reset_speaker", int'(bus.speaker), 0);
    check("reset_sounding", int'(bus.sounding), 0);
    check("reset_tick", int'(bus.period_tick), 0);
    reset = 1'b0;
    silent_window(20, "idle_disabled");

    // 1: A4 mid octave, three full periods.
    set_in(1'b1, 4'd6, 2'd1);
    expect_rise("t1_rise");
    repeat (3) push_period(HP_A, 1'b0);
    wait_ticks(3, "t1");

    // 2: octave sweep; each change lands after the period in progress.
    bus.octave = 2'd0;
    push_period(HP_A, 1'b0);
    push_period(HP_A_LOW, 1'b0);
    wait_ticks(2, "t2a");
    bus.octave = 2'd2;
    push_period(HP_A_LOW, 1'b0);
    push_period(HP_A_HIG, 1'b0);
    push_period(HP_A_HIG, 1'b0);
    wait_ticks(3, "t2b");
    bus.octave = 2'd3;
    push_period(HP_A_HIG, 1'b1);
    wait_ticks(1, "t2c");
    silent_window(1500, "t2_octave3_silent");

    // 3: switch A -> C at cnt=300 of the high phase.
    bus.octave = 2'd1;
    expect_rise("t3_rise");
    repeat (300) @(negedge clk);
    bus.note = 4'd1;
    push_period(HP_A, 1'b0);
    push_period(HP_C, 1'b0);
    push_period(HP_C, 1'b0);
    wait_ticks(3, "t3");

    // 4: drop enable mid-high, then re-enable.
    repeat (100) @(negedge clk);
    bus.enable = 1'b0;
    push_period(HP_C, 1'b1);
    wait_ticks(1, "t4");
    silent_window(2000, "t4_disabled_silent");
    bus.enable = 1'b1;
    expect_rise("t4_rerise");

    // 5: rest codes, and A -> rest exactly at the boundary.
    bus.note = 4'd0;
    push_period(HP_C, 1'b1);
    wait_ticks(1, "t5a");
    silent_window(1500, "t5_note0_silent");
    bus.note = 4'd9;
    silent_window(1500, "t5_note9_silent");
    bus.note = 4'd6;
    expect_rise("t5_rise");
    repeat (50) @(negedge clk);
    bus.note = 4'd0;
    push_period(HP_A, 1'b1);
    wait_ticks(1, "t5b");
    silent_window(1500, "t5_rest_silent");

    // 6: reset mid high phase, then a fresh restart.
    bus.note = 4'd6;
    expect_rise("t6_rise");
    repeat (500) @(negedge clk);
    check("t6_high_before_reset", int'(bus.speaker), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_speaker", int'(bus.speaker), 0);
    check("t6_reset_sounding", int'(bus.sounding), 0);
    check("t6_reset_tick", int'(bus.period_tick), 0);
    reset = 1'b0;
    expect_rise("t6_restart");
    push_period(HP_A, 1'b0);
    push_period(HP_A, 1'b0);
    wait_ticks(2, "t6a");
    bus.enable = 1'b0;
    push_period(HP_A, 1'b1);
    wait_ticks(1, "t6b");
    silent_window(300, "t6_end_silent");

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_gen.md
Name: buzzer_tone_gen

Overview:
- Downstream stage of the auto-play sequencer; consumes its 4-bit note code and 2-bit octave and drives the 1-bit buzzer pin with a square wave.
- A per-note half-period counter generates the tone.
- Note, octave and enable changes take effect only at full-period boundaries, so the buzzer never sees a truncated pulse.
- Exposes sounding status and a period tick for LEDs and verification.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; all half-period constants derive from it.
- CNT_W, 20, counter width; must hold 2*CLK_HZ/(2*262).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  play gate (the sequencer's play_state); 0 = silence after the current period.
- note  in  4  note code: 1..7 = C,D,E,F,G,A,B; 0 and 8..15 = rest/silence (includes the end-of-song marker).
- octave  in  2  0 = low, 1 = mid, 2 = high, 3 = silence.
- speaker  out  1  square wave to the buzzer.
- sounding  out  1  high while in PLAY.
- period_tick  out  1  one-cycle pulse at the end of each completed full period.

Behaviour:
- Mid-octave half-period HP_mid(n) = CLK_HZ/(2*F) with truncating integer division.
  - F: C4=262, D=294, E=330, F=349, G=392, A=440, B=494 Hz.
  - Low octave: HP_mid<<1. High octave: HP_mid>>1.
  - Values are constants computed at elaboration; no runtime divider.
- Input valid (V) := enable && note in 1..7 && octave != 3.
- Registers: state, cnt[CNT_W], hp (latched half-period), speaker, period_tick.
- Reset (synchronous, highest priority): state=SILENT, cnt=0, hp=0, speaker=0, sounding=0, period_tick=0. Applies mid-period, with no tail pulse.
- SILENT:
  - speaker=0, cnt=0.
  - If V: latch hp from (note, octave), speaker<=1, cnt<=0, go PLAY. The first high cycle appears 1 clk after V is sampled.
- PLAY:
  - cnt increments each cycle.
  - When cnt==hp-1: cnt<=0 and a phase ends.
  - High phase ends: speaker<=0.
  - Low phase ends (full-period boundary): period_tick<=1 for one cycle, then re-sample inputs:
    - V false: speaker stays 0, go SILENT.
    - V true: re-latch hp from the current (note, octave), which may differ, speaker<=1, stay PLAY.
- Input changes mid-period are ignored until the boundary.
  - Worst-case change latency: one full period of the old tone + 1 clk.
  - No input registering is required beyond the boundary sample.
- Same note held: continuous square wave with exact period 2*hp and 50% duty.
- enable falling while high: the high and low phases complete, then SILENT; speaker is never left high.
- sounding = (state==PLAY), registered.
- period_tick is 0 in SILENT.
- No articulation gap between identical consecutive notes; that is the sequencer's job (rest code).

Test Plan:
1. CLK_HZ=1_000_000; reset; enable=1, note=6, octave=1 -> speaker rises 1 clk later; high 1136 clk, low 1136 clk, repeating; period_tick every 2272 clk; sounding=1.
2. Octave sweep with note=6 -> octave=0 gives half-period 2272; octave=2 gives 568; octave=3 -> speaker stays 0, sounding=0.
3. While playing A4 (hp=1136), switch note to 1 at cnt=300 of the high phase -> the current A period completes fully (1136 high + 1136 low), then the C4 half-period of 1908 starts with speaker high; no short pulse at any point.
4. Drop enable mid-high-phase -> high and low phases finish, period_tick pulses, then SILENT; speaker=0, sounding=0, and no further toggles while enable=0. Re-assert enable -> speaker rises 1 clk after sampling.
5. Rest/end codes: note=0, then note=9 with enable=1 -> speaker stays 0; switching from A4 to note=0 -> silence begins exactly at the period boundary.
6. Assert reset at cnt=500 with speaker=1 -> next cycle speaker=0, sounding=0, period_tick=0. After release with V true, tone restarts from a fresh high phase.
